// File: rtl/myproject_mac_accum_pkg.sv
// Shared widths, FSM encodings and requantisation constants for the MAC accumulate stage.
// Imported by the interface, the round/saturate helper and the top.
package myproject_accum_pkg;

  localparam int PROD_WIDTH = 29;
  localparam int ACC_WIDTH  = 40;
  localparam int OUT_WIDTH  = 16;
  localparam int SHIFT      = 10;

  typedef logic [1:0] state_t;

  localparam state_t ST_ACCUM = 2'd0;
  localparam state_t ST_ROUND = 2'd1;
  localparam state_t ST_HOLD  = 2'd2;

  // Constants at accumulator width so the comparisons stay signed and width-matched.
  localparam logic signed [ACC_WIDTH-1:0] ROUND_HALF =
    {{(ACC_WIDTH-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

endpackage

// File: rtl/myproject_mac_accum_if.sv
// Product-in / result-out handshake bundle of the accumulate stage.
// slave = accumulate stage view, master = producer/consumer (testbench) view.
interface myproject_mac_accum_if;
  import myproject_accum_pkg::*;

  logic signed [PROD_WIDTH-1:0] prod_din;
  logic                         prod_valid;
  logic                         prod_last;
  logic                         prod_ready;
  logic signed [OUT_WIDTH-1:0]  bias_din;
  logic signed [OUT_WIDTH-1:0]  res_dout;
  logic                         res_valid;
  logic                         res_ready;
  logic                         res_ovf;

  modport slave (
    input  prod_din, prod_valid, prod_last, bias_din, res_ready,
    output prod_ready, res_dout, res_valid, res_ovf
  );

  modport master (
    output prod_din, prod_valid, prod_last, bias_din, res_ready,
    input  prod_ready, res_dout, res_valid, res_ovf
  );

endinterface

// File: rtl/myproject_round_sat.sv
// Combinational round-half-up, arithmetic shift and saturate from accumulator to output width.
// Zero latency; no handshake, callers register the result.
module myproject_round_sat #(
  parameter int ACC_W = 40,
  parameter int OUT_W = 16,
  parameter int SH    = 10
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [OUT_W-1:0] o_res,
  output logic                    o_ovf
);

  localparam logic signed [ACC_W-1:0] HALF = {{(ACC_W-SH){1'b0}}, 1'b1, {(SH-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_shr;
  logic                    w_hi;
  logic                    w_lo;

  assign w_sum = i_acc + HALF;
  assign w_shr = w_sum >>> SH;
  assign w_hi  = (w_shr > MAXV);
  assign w_lo  = (w_shr < MINV);

  always_comb begin
    o_res = w_shr[OUT_W-1:0];
    o_ovf = 1'b0;
    if (w_hi) begin
      o_res = MAXV[OUT_W-1:0];
      o_ovf = 1'b1;
    end else if (w_lo) begin
      o_res = MINV[OUT_W-1:0];
      o_ovf = 1'b1;
    end
  end

endmodule

// File: rtl/myproject_mac_accum.sv
// Sums a frame of signed products on a shifted bias, then rounds/saturates to 16 bits.
// 1 beat/cycle in; result valid 2 cycles after last beat; input stalls until result is taken.
module myproject_mac_accum
  import myproject_accum_pkg::*;
(
  input logic                  ap_clk,
  input logic                  ap_rst,
  myproject_mac_accum_if.slave ifc
);

  state_t                       r_state;
  logic                         r_first;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic signed [OUT_WIDTH-1:0]  r_res;
  logic                         r_ovf;
  logic                         r_vld;

  logic                         w_beat;
  logic signed [ACC_WIDTH-1:0]  w_bias_acc;
  logic signed [ACC_WIDTH-1:0]  w_prod_acc;
  logic signed [ACC_WIDTH-1:0]  w_base;
  logic signed [ACC_WIDTH-1:0]  w_acc_nxt;
  logic signed [OUT_WIDTH-1:0]  w_res;
  logic                         w_ovf;

  assign ifc.prod_ready = (r_state == ST_ACCUM);
  assign ifc.res_dout   = r_res;
  assign ifc.res_ovf    = r_ovf;
  assign ifc.res_valid  = r_vld;

  assign w_beat     = ifc.prod_valid && ifc.prod_ready;
  assign w_bias_acc = {{(ACC_WIDTH-OUT_WIDTH-SHIFT){ifc.bias_din[OUT_WIDTH-1]}},
                       ifc.bias_din, {SHIFT{1'b0}}};
  assign w_prod_acc = {{(ACC_WIDTH-PROD_WIDTH){ifc.prod_din[PROD_WIDTH-1]}}, ifc.prod_din};
  // The first beat restarts the sum from the bias, so no explicit clear is needed between frames.
  assign w_base     = r_first ? w_bias_acc : r_acc;
  assign w_acc_nxt  = w_base + w_prod_acc;

  myproject_round_sat #(
    .ACC_W (ACC_WIDTH),
    .OUT_W (OUT_WIDTH),
    .SH    (SHIFT)
  ) u_round_sat (
    .i_acc (r_acc),
    .o_res (w_res),
    .o_ovf (w_ovf)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= ST_ACCUM;
      r_first <= 1'b1;
      r_acc   <= '0;
      r_res   <= '0;
      r_ovf   <= 1'b0;
      r_vld   <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_beat) begin
            r_acc   <= w_acc_nxt;
            r_first <= ifc.prod_last;
            if (ifc.prod_last) begin
              r_state <= ST_ROUND;
            end
          end
        end
        ST_ROUND: begin
          r_res   <= w_res;
          r_ovf   <= w_ovf;
          r_vld   <= 1'b1;
          r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (ifc.res_ready) begin
            r_vld   <= 1'b0;
            r_state <= ST_ACCUM;
          end
        end
        default: begin
          r_state <= ST_ACCUM;
          r_first <= 1'b1;
          r_vld   <= 1'b0;
        end
      endcase
    end
  end

endmodule
